// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Multiplies use
// shift-add and divides use a restoring divider, both on operand magnitudes.
// The sign is applied as the last step. Every operation takes XLEN iterations.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - launch an operation with op/rs1/rs2 (accepted in IDLE or DONE)
//   kill    - abort the operation in flight; has priority over start
//   op      - RV32M funct3 encoding
//   rs1     - multiplicand / dividend
//   rs2     - multiplier / divisor
//   busy    - high while calculating
//   done    - one-cycle completion pulse
//   result  - result of the last completed operation
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0] CNT_LAST = XLEN'(XLEN - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode at launch time
  logic            sgn1, sgn2, neg1, neg2, res_neg;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    sgn1 = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn2 = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg1 = sgn1 & rs1[XLEN-1];
    neg2 = sgn2 & rs2[XLEN-1];
    mag1 = neg1 ? -rs1 : rs1;
    mag2 = neg2 ? -rs2 : rs2;
    // neg captures the final sign fix-up for the whole op. Division by zero
    // keeps an unsigned all-ones quotient; the remainder then equals rs1.
    case (op)
      3'b001, 3'b010: res_neg = neg1 ^ neg2;
      3'b100:         res_neg = (neg1 ^ neg2) & (rs2 != '0);
      3'b110:         res_neg = neg1;
      default:        res_neg = 1'b0;
    endcase
  end

  // One iteration. Multiply: {hi,lo} shifts right with lo holding the
  // remaining multiplier bits. Divide: hi is the partial remainder, lo shifts
  // the dividend out at the top and the quotient in at the bottom.
  logic [XLEN:0]   add_sum, rem_shift, rem_diff;
  logic [XLEN-1:0] hi_step, lo_step;

  always_comb begin
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_shift = {hi_q, lo_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (op_q[2]) begin
      // The partial remainder stays below the divisor, so the difference
      // always fits and its top bit is a true borrow.
      if (!rem_diff[XLEN]) begin
        hi_step = rem_diff[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = rem_shift[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = add_sum[XLEN:1];
      lo_step = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Final result from the last iteration's outputs
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    prod   = {hi_step, lo_step};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_step : lo_step;
    rem_s  = neg_q ? -hi_step : hi_step;
    case (op_q)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CALC: begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + XLEN'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            result_d = final_res;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (start) begin
            state_d = S_CALC;
            cnt_d   = '0;
            op_d    = op;
            neg_d   = res_neg;
            b_d     = mag2;
            hi_d    = '0;
            lo_d    = mag1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (XLEN=32)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Launch one op and wait for done. lat = edges after the accepting edge
  // until done is seen; bcnt = samples with busy high.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt, output bit to);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0; to = 1'b1; res = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        to = 1'b0; res = result;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul_timing;
    logic [31:0] r; int lat, bcnt; bit to;
    do_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bcnt, to);
    checks++; if (to) begin errors++; $display("FAIL mul_timeout got=timeout want=done"); end
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got=%h want=ffffffeb", r); end
    checks++; if (lat != 32) begin errors++; $display("FAIL mul_latency got=%0d want=32", lat); end
    checks++; if (bcnt != 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d want=32", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_in_done got=%b want=0", busy); end
  endtask

  task automatic test_vectors;
    logic [2:0]  vo [12];
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] ve [12];
    logic [31:0] r; int lat, bcnt; bit to;
    vo[0]  = 3'b001; va[0]  = 32'h80000000; vb[0]  = 32'h80000000; ve[0]  = 32'h40000000;
    vo[1]  = 3'b010; va[1]  = 32'hFFFFFFFF; vb[1]  = 32'hFFFFFFFF; ve[1]  = 32'hFFFFFFFF;
    vo[2]  = 3'b011; va[2]  = 32'hFFFFFFFF; vb[2]  = 32'hFFFFFFFF; ve[2]  = 32'hFFFFFFFE;
    vo[3]  = 3'b100; va[3]  = 32'hFFFFFFF9; vb[3]  = 32'd2;        ve[3]  = 32'hFFFFFFFD;
    vo[4]  = 3'b110; va[4]  = 32'hFFFFFFF9; vb[4]  = 32'd2;        ve[4]  = 32'hFFFFFFFF;
    vo[5]  = 3'b101; va[5]  = 32'd100;      vb[5]  = 32'd7;        ve[5]  = 32'd14;
    vo[6]  = 3'b111; va[6]  = 32'd100;      vb[6]  = 32'd7;        ve[6]  = 32'd2;
    vo[7]  = 3'b101; va[7]  = 32'd5;        vb[7]  = 32'd0;        ve[7]  = 32'hFFFFFFFF;
    vo[8]  = 3'b111; va[8]  = 32'd5;        vb[8]  = 32'd0;        ve[8]  = 32'd5;
    vo[9]  = 3'b100; va[9]  = 32'h80000000; vb[9]  = 32'hFFFFFFFF; ve[9]  = 32'h80000000;
    vo[10] = 3'b110; va[10] = 32'h80000000; vb[10] = 32'hFFFFFFFF; ve[10] = 32'h0;
    vo[11] = 3'b100; va[11] = 32'hFFFFFFF9; vb[11] = 32'd0;        ve[11] = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++) begin
      do_op(vo[i], va[i], vb[i], r, lat, bcnt, to);
      checks++;
      if (to || r !== ve[i] || lat != 32)
        begin errors++; $display("FAIL vector_%0d op=%b got=%h lat=%0d timeout=%b want=%h lat=32", i, vo[i], r, lat, to, ve[i]); end
    end
  endtask

  task automatic test_start_while_busy_and_kill;
    int dcnt; int lat;
    @(negedge clk);
    op = 3'b000; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    dcnt = 0; lat = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (i == 10) start = 1'b0;
      if (done) begin dcnt++; if (lat == 0) lat = i + 1; end
    end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL busy_start_done_count got=%0d want=1", dcnt); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL busy_start_result got=%h want=0000000c", result); end
    checks++; if (lat != 32) begin errors++; $display("FAIL busy_start_latency got=%0d want=32", lat); end

    @(negedge clk);
    op = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got=%b want=0", busy); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) dcnt++; end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL kill_no_done got=%0d want=0", dcnt); end
    checks++; if (result !== 32'd12) begin errors++; $display("FAIL kill_result_hold got=%h want=0000000c", result); end
  endtask

  task automatic test_reset_mid_calc;
    logic [31:0] r; int lat, bcnt, dcnt; bit to;
    @(negedge clk);
    op = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got=%h want=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) dcnt++; end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d want=0", dcnt); end
    do_op(3'b000, 32'd2, 32'd2, r, lat, bcnt, to);
    checks++;
    if (to || r !== 32'd4 || lat != 32)
      begin errors++; $display("FAIL rst_mid_after_mul got=%h lat=%0d timeout=%b want=00000004 lat=32", r, lat, to); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int lat, bcnt, dcnt; bit to;
    do_op(3'b011, 32'h00010000, 32'h00030000, r, lat, bcnt, to);
    checks++; if (to || r !== 32'h3) begin errors++; $display("FAIL b2b_first got=%h timeout=%b want=00000003", r, to); end
    // still in the DONE cycle: relaunch from DONE
    op = 3'b110; rs1 = 32'hFFFFFF9C; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_relaunch_busy got=%b want=1", busy); end
    lat = 0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1; lat++;
      if (done) begin to = 1'b0; break; end
    end
    checks++;
    if (to || result !== 32'hFFFFFFFE || lat != 32)
      begin errors++; $display("FAIL b2b_second got=%h lat=%0d timeout=%b want=fffffffe lat=32", result, lat, to); end
    // kill and start together in DONE: start dropped
    start = 1'b1; kill = 1'b1; op = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_over_start_busy got=%b want=0", busy); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) dcnt++; end
    checks++;
    if (dcnt != 0 || result !== 32'hFFFFFFFE)
      begin errors++; $display("FAIL kill_over_start_hold got=%h dones=%0d want=fffffffe dones=0", result, dcnt); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_vectors();
    test_start_while_busy_and_kill();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
